add_sub_cell_bank: RTL and testbench
====================================

// Module: add_sub_cell_bank
// PURPOSE
// - Registered WIDTH-bit arithmetic bank built from 1-bit cells, three paths side by side:
//   a ripple of direct full_adder cells, a ripple of full adders each built from two
//   half adders, and a ripple of full_sub cells.
// - Both adder paths compute the same function, so the block also checks one against the other.
// - Used as the datapath-level home of the adder/subtractor primitives.
// PARAMETERS
// - WIDTH  4  operand width in bits; legal range 1..32.
//   WIDTH=1 reduces to a single full_adder, full_adder_using_2half_adder and full_sub.
// PORTS
// - clk       in   1      clock; all state updates on the rising edge
// - rst       in   1      synchronous, active-high reset
// - in_valid  in   1      capture enable for a/b/cin/bin
// - a         in   WIDTH  operand A (minuend for subtract)
// - b         in   WIDTH  operand B (subtrahend for subtract)
// - cin       in   1      carry-in, LSB cell of both adder paths
// - bin       in   1      borrow-in, LSB cell of subtract path
// - sum1      out  WIDTH  sum, direct full-adder path
// - cout1     out  1      carry-out, direct path
// - sum2      out  WIDTH  sum, two-half-adder path
// - cout2     out  1      carry-out, two-half-adder path
// - diff      out  WIDTH  difference a-b-bin (mod 2^WIDTH)
// - bout      out  1      borrow-out: 1 when a < b+bin (unsigned)
// - out_valid out  1      registered copy of in_valid
// - mismatch  out  1      sticky adder cross-check error (see CONFIGURATION)
// BEHAVIOUR
// - Direct cell: s = a^b^c; co = (a&b) | (c&(a^b)).
// - Half adder: s = x^y; c = x&y.
// - Two-HA cell: HA1(a,b) -> p,g; HA2(p,c) -> s,t; co = g|t.
//   Must be structurally separate from the direct cell; no sharing of logic.
// - Subtract cell: d = a^b^bi; bo = (~a&b) | (~(a^b)&bi).
// - Ripple: bit i carry/borrow-in = bit i-1 carry/borrow-out.
//   Bit 0 uses cin (both adder paths) and bin (subtract path).
//   cout1/cout2/bout = MSB cell outputs.
// - Arithmetic is unsigned; {cout,sum} = a+b+cin exactly (WIDTH+1 bits);
//   diff wraps mod 2^WIDTH and bout flags the wrap.
// - Latency 1 cycle: on a clk edge with in_valid=1, all results are registered from that
//   cycle's inputs. With in_valid=0, all results hold their values.
// - out_valid <= in_valid every cycle (0 after a single idle cycle).
// - Reset: on a clk edge with rst=1, every output (sums, carries, diff, bout, out_valid,
//   mismatch) is set to 0. rst overrides in_valid when both are high.
// - Releasing reset with in_valid=1 captures on the first edge after rst falls.
// - Boundary cases:
//   - all-ones + all-ones + cin=1 -> sum = all-ones, cout = 1;
//   - 0 - all-ones - bin=1 -> diff = 0, bout = 1;
//   - a=b with bin=0 -> diff = 0, bout = 0.
// - No combinational path from inputs to outputs.
// CONFIGURATION
// - Macro ADD_SUB_XCHECK_EN.
// - When defined: each valid capture compares the next {cout1,sum1} against {cout2,sum2}.
//   Any difference sets mismatch to 1; mismatch then stays 1 until rst.
// - When undefined: mismatch is a constant 0 and no compare logic is built.
// - Sums, carries, diff, bout and out_valid are identical in both builds.
// TESTING
// - WIDTH=1, run all 8 combinations with {a,b,cin}=bin pattern (bin=cin), 10-time-unit steps.
//   Required: a=1,b=1,cin=1 -> sum1=sum2=1, cout1=cout2=1;
//   a=0,b=1,bin=1 -> diff=0, bout=1; a=1,b=0,bin=1 -> diff=0, bout=0.
// - WIDTH=4, a=4'hF, b=4'h1, cin=0, bin=0 -> next cycle sum1=sum2=4'h0, cout=1,
//   diff=4'hE, bout=0, out_valid=1.
// - WIDTH=4, a=4'h0, b=4'h1, bin=0 -> diff=4'hF, bout=1.
//   Then drop in_valid, change a/b -> outputs hold and out_valid=0.
// - Assert rst together with in_valid=1, a=4'hF, b=4'hF -> all outputs 0 on that edge;
//   deassert rst -> next valid capture yields sum=4'hE, cout=1.
// - Exhaustive WIDTH=4 sweep (512 add vectors, 512 sub vectors) against a reference model;
//   with ADD_SUB_XCHECK_EN defined, mismatch stays 0 throughout.
// - Build without ADD_SUB_XCHECK_EN -> mismatch is 0 for the whole sweep.

Source files
------------

// File: rtl/add_sub_cell_bank.sv
// Registered add/sub bank built from 1-bit cells, three ripple paths.
// Optional macro ADD_SUB_XCHECK_EN builds the sticky adder cross-check.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ c;
  assign co = (a & b) | (c & (a ^ b));
endmodule

module half_adder (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);
  assign s = x ^ y;
  assign c = x & y;
endmodule

module full_adder_using_2half_adder (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic s,
  output logic co
);
  logic p, g, t;

  half_adder u_ha1 (.x(a), .y(b), .s(p), .c(g));
  half_adder u_ha2 (.x(p), .y(c), .s(s), .c(t));

  assign co = g | t;
endmodule

module full_sub (
  input  logic a,
  input  logic b,
  input  logic bi,
  output logic d,
  output logic bo
);
  assign d  = a ^ b ^ bi;
  assign bo = (~a & b) | (~(a ^ b) & bi);
endmodule

module add_sub_cell_bank #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             bin,
  output logic [WIDTH-1:0] sum1,
  output logic             cout1,
  output logic [WIDTH-1:0] sum2,
  output logic             cout2,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             out_valid,
  output logic             mismatch
);
  logic [WIDTH:0]   c1, c2, bw;
  logic [WIDTH-1:0] s1, s2, d;

  assign c1[0] = cin;
  assign c2[0] = cin;
  assign bw[0] = bin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    full_adder u_fa (
      .a(a[i]), .b(b[i]), .c(c1[i]),
      .s(s1[i]), .co(c1[i+1])
    );
    full_adder_using_2half_adder u_fa2 (
      .a(a[i]), .b(b[i]), .c(c2[i]),
      .s(s2[i]), .co(c2[i+1])
    );
    full_sub u_fs (
      .a(a[i]), .b(b[i]), .bi(bw[i]),
      .d(d[i]), .bo(bw[i+1])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum1      <= '0;
      cout1     <= 1'b0;
      sum2      <= '0;
      cout2     <= 1'b0;
      diff      <= '0;
      bout      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        sum1  <= s1;
        cout1 <= c1[WIDTH];
        sum2  <= s2;
        cout2 <= c2[WIDTH];
        diff  <= d;
        bout  <= bw[WIDTH];
      end
    end
  end

`ifdef ADD_SUB_XCHECK_EN
  // Sticky: once the two adder structures disagree, hold until reset.
  always_ff @(posedge clk) begin
    if (rst)
      mismatch <= 1'b0;
    else if (in_valid && ({c1[WIDTH], s1} != {c2[WIDTH], s2}))
      mismatch <= 1'b1;
  end
`else
  assign mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_add_sub_cell_bank.sv
// Directed bench for add_sub_cell_bank at WIDTH=1 and WIDTH=4.
// Expected values are hand-written constants or plain integer arithmetic.
module tb_add_sub_cell_bank;
  logic       clk = 1'b0;
  logic       rst, in_valid, cin, bin;
  logic       a1, b1;
  logic [3:0] a4, b4;

  logic       n_sum1, n_cout1, n_sum2, n_cout2;
  logic       n_diff, n_bout, n_ov, n_mm;
  logic [3:0] w_sum1, w_sum2, w_diff;
  logic       w_cout1, w_cout2, w_bout, w_ov, w_mm;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  add_sub_cell_bank #(.WIDTH(1)) u_n (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .a(a1), .b(b1), .cin(cin), .bin(bin),
    .sum1(n_sum1), .cout1(n_cout1),
    .sum2(n_sum2), .cout2(n_cout2),
    .diff(n_diff), .bout(n_bout),
    .out_valid(n_ov), .mismatch(n_mm)
  );

  add_sub_cell_bank #(.WIDTH(4)) u_w (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .a(a4), .b(b4), .cin(cin), .bin(bin),
    .sum1(w_sum1), .cout1(w_cout1),
    .sum2(w_sum2), .cout2(w_cout2),
    .diff(w_diff), .bout(w_bout),
    .out_valid(w_ov), .mismatch(w_mm)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_w(input string tag,
                       input logic [3:0] s, input logic c,
                       input logic [3:0] d, input logic bo);
    chk({tag, ".sum1"}, w_sum1, s);
    chk({tag, ".sum2"}, w_sum2, s);
    chk({tag, ".cout1"}, w_cout1, c);
    chk({tag, ".cout2"}, w_cout2, c);
    chk({tag, ".diff"}, w_diff, d);
    chk({tag, ".bout"}, w_bout, bo);
  endtask

  initial begin
    logic [4:0] rs, rd;
    logic [1:0] ns, nd;
    rst = 1'b1; in_valid = 1'b0;
    cin = 1'b0; bin = 1'b0;
    a1 = 1'b0; b1 = 1'b0; a4 = 4'h0; b4 = 4'h0;
    @(negedge clk);
    tick();
    tick();

    chk_w("reset", 4'h0, 1'b0, 4'h0, 1'b0);
    chk("reset.ov", w_ov, 1'b0);
    chk("reset.mm", w_mm, 1'b0);
    chk("reset.n_sum1", n_sum1, 1'b0);
    chk("reset.n_ov", n_ov, 1'b0);

    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      {a1, b1, cin} = i[2:0];
      bin = cin;
      tick();
      ns = {1'b0, a1} + {1'b0, b1} + {1'b0, cin};
      nd = {1'b0, a1} - {1'b0, b1} - {1'b0, bin};
      chk("w1.sum1", n_sum1, ns[0]);
      chk("w1.sum2", n_sum2, ns[0]);
      chk("w1.cout1", n_cout1, ns[1]);
      chk("w1.cout2", n_cout2, ns[1]);
      chk("w1.diff", n_diff, nd[0]);
      chk("w1.bout", n_bout, nd[1]);
      chk("w1.ov", n_ov, 1'b1);
      @(negedge clk);
    end

    // Hand-checked WIDTH=1 corners from the last sweep points.
    a1 = 1; b1 = 1; cin = 1; bin = 1;
    tick();
    chk("w1.111.sum1", n_sum1, 1'b1);
    chk("w1.111.cout2", n_cout2, 1'b1);
    @(negedge clk);
    a1 = 0; b1 = 1; bin = 1;
    tick();
    chk("w1.011.diff", n_diff, 1'b0);
    chk("w1.011.bout", n_bout, 1'b1);
    @(negedge clk);
    a1 = 1; b1 = 0; bin = 1;
    tick();
    chk("w1.101.diff", n_diff, 1'b0);
    chk("w1.101.bout", n_bout, 1'b0);

    @(negedge clk);
    a4 = 4'hF; b4 = 4'h1; cin = 0; bin = 0;
    tick();
    chk_w("f_plus_1", 4'h0, 1'b1, 4'hE, 1'b0);
    chk("f_plus_1.ov", w_ov, 1'b1);

    @(negedge clk);
    a4 = 4'h0; b4 = 4'h1;
    tick();
    chk_w("0_minus_1", 4'h1, 1'b0, 4'hF, 1'b1);

    @(negedge clk);
    in_valid = 1'b0; a4 = 4'h5; b4 = 4'h3;
    tick();
    chk_w("hold", 4'h1, 1'b0, 4'hF, 1'b1);
    chk("hold.ov", w_ov, 1'b0);

    @(negedge clk);
    rst = 1'b1; in_valid = 1'b1;
    a4 = 4'hF; b4 = 4'hF;
    tick();
    chk_w("rst_wins", 4'h0, 1'b0, 4'h0, 1'b0);
    chk("rst_wins.ov", w_ov, 1'b0);

    @(negedge clk);
    rst = 1'b0;
    tick();
    chk_w("after_rst", 4'hE, 1'b1, 4'h0, 1'b0);
    chk("after_rst.ov", w_ov, 1'b1);

    @(negedge clk);
    cin = 1'b1;
    tick();
    chk("ones.sum1", w_sum1, 4'hF);
    chk("ones.cout1", w_cout1, 1'b1);
    chk("ones.sum2", w_sum2, 4'hF);

    @(negedge clk);
    a4 = 4'h0; b4 = 4'hF; bin = 1'b1;
    tick();
    chk("zero_sub.diff", w_diff, 4'h0);
    chk("zero_sub.bout", w_bout, 1'b1);

    @(negedge clk);
    a4 = 4'h7; b4 = 4'h7; bin = 1'b0;
    tick();
    chk("eq.diff", w_diff, 4'h0);
    chk("eq.bout", w_bout, 1'b0);

    for (int i = 0; i < 512; i++) begin
      @(negedge clk);
      a4 = i[3:0]; b4 = i[7:4];
      cin = i[8]; bin = i[8];
      tick();
      rs = {1'b0, a4} + {1'b0, b4} + {4'h0, cin};
      rd = {1'b0, a4} - {1'b0, b4} - {4'h0, bin};
      chk_w("sweep", rs[3:0], rs[4], rd[3:0], rd[4]);
      chk("sweep.mm", w_mm, 1'b0);
    end

    @(negedge clk);
    in_valid = 1'b0;
    tick();
    chk("idle.ov", w_ov, 1'b0);
    chk("idle.mm", w_mm, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=done");
    $fatal(1, "timeout");
  end
endmodule
